// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch stage:
// FSM states, buffered entry layout and the NOP filler.
package fetch_pkg;

  localparam logic [31:0] NOP_INST_C = 32'h0000_0013;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    HOLD,
    DROP
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/instruction_fetch_if.sv
// Instruction-memory request/grant/response bus.
// master = fetch stage, slave = memory.
interface instruction_fetch_if;

  logic        im_req;
  logic [31:0] im_addr;
  logic        im_gnt;
  logic        im_rvalid;
  logic [31:0] im_rdata;

  modport master (
    output im_req,
    output im_addr,
    input  im_gnt,
    input  im_rvalid,
    input  im_rdata
  );

  modport slave (
    input  im_req,
    input  im_addr,
    output im_gnt,
    output im_rvalid,
    output im_rdata
  );

endinterface

// File: rtl/fetch_buffer.sv
// Small FIFO of fetched {pc, inst} entries between
// the memory response and the decode stage.
module fetch_buffer
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  fetch_entry_t  entry_i,
  input  logic          pop_i,
  input  logic          flush_i,
  output fetch_entry_t  head_o,
  output logic [CW-1:0] count_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_entry_t  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push;
  logic          do_pop;

  function automatic logic [PW-1:0] inc(
    input logic [PW-1:0] p
  );
    if (int'(p) == DEPTH - 1) return '0;
    return p + PW'(1);
  endfunction

  assign do_push = push_i && !flush_i &&
                   (count_q < CW'(DEPTH));
  assign do_pop  = pop_i && !flush_i &&
                   (count_q != '0);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = inc(wr_ptr_q);
      if (do_pop)  rd_ptr_d = inc(rd_ptr_q);
      count_d = count_q + CW'(do_push)
                        - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // payload needs no reset: count gates visibility
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= entry_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: one outstanding IM request, flush and
// stall handling, and a 2-entry buffer toward decode.
module instruction_fetch
  import fetch_pkg::*;
#(
  parameter int          BUF_DEPTH = 2,
  parameter logic [31:0] NOP_INST  = NOP_INST_C
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [31:0]         pc_in,
  input  logic                PCsrc,
  input  logic                pc_hold,
  input  logic                id_stall,
  instruction_fetch_if.master im,
  output logic                IM_stall,
  output logic                if_valid,
  output logic [31:0]         if_pc,
  output logic [31:0]         if_inst
);

  localparam int CW = $clog2(BUF_DEPTH + 1);

  fetch_state_t  state_q, state_d;
  logic [31:0]   req_pc_q, req_pc_d;
  fetch_entry_t  hold_q, hold_d;
  fetch_entry_t  push_entry;
  fetch_entry_t  head;
  logic [CW-1:0] count;
  logic          has_room;
  logic          push;
  logic          pop;
  logic          req;
  logic          stall;

  assign has_room = count < CW'(BUF_DEPTH);

  always_comb begin
    state_d    = state_q;
    req_pc_d   = req_pc_q;
    hold_d     = hold_q;
    push       = 1'b0;
    push_entry = hold_q;
    req        = 1'b0;
    stall      = 1'b1;
    unique case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        req = has_room && !PCsrc;
        if (im.im_gnt) begin
          if (PCsrc) begin
            state_d = DROP;
          end else if (req) begin
            req_pc_d = pc_in;
            state_d  = WAIT;
          end
        end
      end
      WAIT: begin
        if (im.im_rvalid) begin
          if (PCsrc) begin
            state_d = REQ;
          end else if (pc_hold) begin
            hold_d  = '{pc: req_pc_q,
                        inst: im.im_rdata};
            state_d = HOLD;
          end else begin
            push       = 1'b1;
            push_entry = '{pc: req_pc_q,
                           inst: im.im_rdata};
            stall      = 1'b0;
            state_d    = REQ;
          end
        end else if (PCsrc) begin
          state_d = DROP;
        end
      end
      HOLD: begin
        stall = pc_hold;
        if (PCsrc) begin
          state_d = REQ;
        end else if (!pc_hold) begin
          push    = 1'b1;
          state_d = REQ;
        end
      end
      // the in-flight response belongs to a flushed path
      DROP: if (im.im_rvalid) state_d = REQ;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      req_pc_q <= '0;
      hold_q   <= '0;
    end else begin
      state_q  <= state_d;
      req_pc_q <= req_pc_d;
      hold_q   <= hold_d;
    end
  end

  assign pop = if_valid && !id_stall && !PCsrc;

  fetch_buffer #(
    .DEPTH (BUF_DEPTH)
  ) u_buf (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .entry_i (push_entry),
    .pop_i   (pop),
    .flush_i (PCsrc),
    .head_o  (head),
    .count_o (count)
  );

  assign im.im_req  = req;
  assign im.im_addr = (state_q == REQ) ? pc_in
                                       : req_pc_q;

  assign IM_stall = stall;
  assign if_valid = count != '0;
  assign if_pc    = if_valid ? head.pc : 32'h0;
  assign if_inst  = if_valid ? head.inst : NOP_INST;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with a
// transaction-level reference model checked each cycle.
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_in;
  logic        PCsrc;
  logic        pc_hold;
  logic        id_stall;
  logic        IM_stall;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_inst;

  instruction_fetch_if bus ();

  instruction_fetch dut (
    .clk      (clk),
    .rst      (rst),
    .pc_in    (pc_in),
    .PCsrc    (PCsrc),
    .pc_hold  (pc_hold),
    .id_stall (id_stall),
    .im       (bus),
    .IM_stall (IM_stall),
    .if_valid (if_valid),
    .if_pc    (if_pc),
    .if_inst  (if_inst)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string n,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h",
               n, got, exp);
    end
  endtask

  // reference model: transactions, not states
  bit          known = 0;
  bit          started;
  bit          outst;
  bit          drop;
  bit          held_v;
  logic [31:0] out_pc;
  logic [31:0] held_pc, held_inst;
  logic [31:0] qpc[$];
  logic [31:0] qin[$];

  function automatic bit m_req();
    return started && !outst && !held_v &&
           qpc.size() < 2 && !PCsrc;
  endfunction

  function automatic bit m_stall();
    if (held_v) return pc_hold;
    if (outst && !drop && bus.im_rvalid &&
        !PCsrc && !pc_hold) return 1'b0;
    return 1'b1;
  endfunction

  always @(negedge clk) begin
    bit er, do_pop, push_v;
    logic [31:0] ppc, pin;
    if (known && !rst) begin
      er = m_req();
      chk("m_if_valid", {31'b0, if_valid},
          {31'b0, qpc.size() > 0});
      chk("m_if_pc", if_pc,
          qpc.size() > 0 ? qpc[0] : 32'h0);
      chk("m_if_inst", if_inst,
          qin.size() > 0 ? qin[0] : 32'h13);
      chk("m_IM_stall", {31'b0, IM_stall},
          {31'b0, m_stall()});
      chk("m_im_req", {31'b0, bus.im_req},
          {31'b0, er});
      if (er) chk("m_im_addr", bus.im_addr, pc_in);
    end
    if (rst) begin
      known   = 1;
      started = 0;
      outst   = 0;
      drop    = 0;
      held_v  = 0;
      qpc.delete();
      qin.delete();
    end else if (known) begin
      er     = m_req();
      do_pop = qpc.size() > 0 && !id_stall && !PCsrc;
      push_v = 0;
      ppc    = 0;
      pin    = 0;
      if (!started) begin
        started = 1;
      end else if (held_v) begin
        if (PCsrc) held_v = 0;
        else if (!pc_hold) begin
          push_v = 1; ppc = held_pc; pin = held_inst;
          held_v = 0;
        end
      end else if (outst) begin
        if (bus.im_rvalid) begin
          outst = 0;
          if (!drop && !PCsrc) begin
            if (pc_hold) begin
              held_v    = 1;
              held_pc   = out_pc;
              held_inst = bus.im_rdata;
            end else begin
              push_v = 1; ppc = out_pc;
              pin = bus.im_rdata;
            end
          end
        end else if (PCsrc) drop = 1;
      end else if (bus.im_gnt) begin
        if (PCsrc) begin
          outst = 1; drop = 1;
        end else if (er) begin
          outst = 1; drop = 0; out_pc = pc_in;
        end
      end
      if (PCsrc) begin
        qpc.delete();
        qin.delete();
      end else begin
        if (do_pop) begin
          void'(qpc.pop_front());
          void'(qin.pop_front());
        end
        if (push_v) begin
          qpc.push_back(ppc);
          qin.push_back(pin);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    PCsrc         = 0;
    pc_hold       = 0;
    id_stall      = 0;
    bus.im_gnt    = 0;
    bus.im_rvalid = 0;
    bus.im_rdata  = 32'hdead_0000;
  endtask

  task automatic do_reset();
    rst = 1;
    idle_inputs();
    pc_in = 0;
    tick();
    tick();
    chk("rst_im_req", {31'b0, bus.im_req}, 0);
    chk("rst_IM_stall", {31'b0, IM_stall}, 1);
    chk("rst_if_valid", {31'b0, if_valid}, 0);
    chk("rst_if_pc", if_pc, 0);
    chk("rst_if_inst", if_inst, 32'h13);
    rst = 0;
    tick();
  endtask

  task automatic wait_req(output bit ok);
    ok = 0;
    for (int i = 0; i < 8; i++) begin
      #1;
      if (bus.im_req) begin
        ok = 1;
        return;
      end
      tick();
    end
    checks++;
    errors++;
    $display("FAIL req_timeout got 0 expected 1");
  endtask

  task automatic fetch(input logic [31:0] pc,
                       input logic [31:0] d);
    bit ok;
    pc_in = pc;
    wait_req(ok);
    if (!ok) return;
    bus.im_gnt = 1;
    tick();
    bus.im_gnt = 0;
    tick();
    bus.im_rvalid = 1;
    bus.im_rdata  = d;
    tick();
    bus.im_rvalid = 0;
  endtask

  initial begin
    bit ok;
    rst = 1;
    idle_inputs();
    pc_in = 0;

    // basic fetch at pc 0
    do_reset();
    #1;
    chk("idle_to_req", {31'b0, bus.im_req}, 1);
    chk("req_addr0", bus.im_addr, 32'h0);
    bus.im_gnt = 1;
    tick();
    bus.im_gnt = 0;
    tick();
    bus.im_rvalid = 1;
    bus.im_rdata  = 32'h0050_0093;
    #1;
    chk("rvalid_stall_low", {31'b0, IM_stall}, 0);
    tick();
    bus.im_rvalid = 0;
    id_stall = 1;
    #1;
    chk("a_valid", {31'b0, if_valid}, 1);
    chk("a_pc", if_pc, 32'h0);
    chk("a_inst", if_inst, 32'h0050_0093);
    chk("a_stall_back", {31'b0, IM_stall}, 1);

    // buffer fills, third request gated
    do_reset();
    id_stall = 1;
    fetch(32'h0, 32'h0000_0111);
    fetch(32'h4, 32'h0000_0222);
    pc_in = 32'h8;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("no_third_req", {31'b0, bus.im_req}, 0);
      tick();
    end
    chk("full_head_pc", if_pc, 32'h0);
    chk("full_head_inst", if_inst, 32'h0000_0111);
    id_stall = 0;
    tick();
    id_stall = 1;
    #1;
    chk("pop_head_pc", if_pc, 32'h4);
    chk("req_after_pop", {31'b0, bus.im_req}, 1);

    // flush while waiting
    do_reset();
    pc_in = 32'h40;
    wait_req(ok);
    bus.im_gnt = 1;
    tick();
    bus.im_gnt = 0;
    PCsrc = 1;
    pc_in = 32'h100;
    tick();
    PCsrc = 0;
    tick();
    bus.im_rvalid = 1;
    bus.im_rdata  = 32'hbad0_0001;
    #1;
    chk("drop_stall", {31'b0, IM_stall}, 1);
    tick();
    bus.im_rvalid = 0;
    #1;
    chk("flush_empty", {31'b0, if_valid}, 0);
    chk("flush_req", {31'b0, bus.im_req}, 1);
    chk("flush_addr", bus.im_addr, 32'h100);
    fetch(32'h100, 32'h0010_0113);
    id_stall = 1;
    #1;
    chk("flush_new_pc", if_pc, 32'h100);

    // response while pc is held
    do_reset();
    id_stall = 1;
    pc_in = 32'h8;
    wait_req(ok);
    bus.im_gnt = 1;
    tick();
    bus.im_gnt = 0;
    pc_hold = 1;
    bus.im_rvalid = 1;
    bus.im_rdata  = 32'h0000_0013;
    #1;
    chk("hold_entry_stall", {31'b0, IM_stall}, 1);
    tick();
    bus.im_rvalid = 0;
    #1;
    chk("hold_stall", {31'b0, IM_stall}, 1);
    chk("hold_not_pushed", {31'b0, if_valid}, 0);
    tick();
    pc_hold = 0;
    #1;
    chk("hold_release", {31'b0, IM_stall}, 0);
    tick();
    #1;
    chk("hold_valid", {31'b0, if_valid}, 1);
    chk("hold_pc", if_pc, 32'h8);
    chk("hold_inst", if_inst, 32'h13);

    // flush together with grant
    do_reset();
    pc_in = 32'h20;
    PCsrc = 1;
    bus.im_gnt = 1;
    tick();
    PCsrc = 0;
    bus.im_gnt = 0;
    tick();
    bus.im_rvalid = 1;
    bus.im_rdata  = 32'hdead_beef;
    #1;
    chk("gnt_drop_stall", {31'b0, IM_stall}, 1);
    tick();
    bus.im_rvalid = 0;
    #1;
    chk("gnt_drop_empty", {31'b0, if_valid}, 0);
    chk("gnt_drop_req", {31'b0, bus.im_req}, 1);

    // reset mid-transaction, stray response
    do_reset();
    pc_in = 32'h30;
    wait_req(ok);
    bus.im_gnt = 1;
    tick();
    bus.im_gnt = 0;
    rst = 1;
    tick();
    rst = 0;
    bus.im_rvalid = 1;
    bus.im_rdata  = 32'h1234_5678;
    #1;
    chk("stray_stall", {31'b0, IM_stall}, 1);
    tick();
    tick();
    bus.im_rvalid = 0;
    #1;
    chk("stray_valid", {31'b0, if_valid}, 0);
    chk("stray_inst", if_inst, 32'h13);
    tick();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter BUF_DEPTH, default 2, SHALL set the fetch-buffer depth; only 2 is supported.
REQ-002 Parameter NOP_INST, default 32'h0000_0013, SHALL set the instruction presented when the buffer is empty.
REQ-003 Port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1: synchronous, active-high reset.
REQ-005 Port pc_in, input, 32: current program counter value (program counter pc_out).
REQ-006 Port PCsrc, input, 1: branch/jump taken this cycle, i.e. flush.
REQ-007 Port pc_hold, input, 1: hazard stall OR DM_stall; the program counter is frozen this cycle.
REQ-008 Port id_stall, input, 1: the decode stage cannot accept an instruction.
REQ-009 Port im_req, output, 1: instruction-memory request.
REQ-010 Port im_addr, output, 32: request address.
REQ-011 Port im_gnt, input, 1: request accepted this cycle.
REQ-012 Port im_rvalid, input, 1: read data valid.
REQ-013 Port im_rdata, input, 32: read data.
REQ-014 Port IM_stall, output, 1: low only in a cycle where the program counter may advance.
REQ-015 Port if_valid, output, 1: the head instruction is valid.
REQ-016 Port if_pc, output, 32: PC of the head instruction.
REQ-017 Port if_inst, output, 32: head instruction.

Function
REQ-018 The FSM SHALL have the states IDLE, REQ, WAIT, HOLD and DROP, with at most one request outstanding.
REQ-019 IDLE SHALL last exactly one cycle after reset, then go to REQ.
REQ-020 In REQ: im_req = (count<2) && !PCsrc, and im_addr = pc_in; on im_gnt, latch req_pc = pc_in and go to WAIT.
REQ-021 im_addr may change only while no grant has been given; an ungranted request may be retargeted.
REQ-022 In WAIT with im_rvalid, !PCsrc and !pc_hold: push {req_pc, im_rdata}, drive IM_stall = 0 for that cycle, and go to REQ.
REQ-023 In WAIT with im_rvalid, !PCsrc and pc_hold: capture the data into the hold register and go to HOLD.
REQ-024 In HOLD: IM_stall = pc_hold; when !pc_hold and !PCsrc, push the held entry and go to REQ.
REQ-025 IM_stall SHALL be 1 in every cycle not covered by REQ-022 and REQ-024.
REQ-026 PCsrc in REQ with im_gnt in the same cycle SHALL go to DROP.
REQ-027 PCsrc in REQ without im_gnt SHALL stay in REQ.
REQ-028 PCsrc in WAIT without im_rvalid SHALL go to DROP.
REQ-029 PCsrc in WAIT with im_rvalid SHALL discard the data and go to REQ.
REQ-030 PCsrc in HOLD SHALL discard the held entry and go to REQ.
REQ-031 DROP SHALL discard the next im_rvalid, then go to REQ; PCsrc while in DROP SHALL stay in DROP.
REQ-032 PCsrc SHALL clear the buffer (count=0) at that edge and suppress any push in the same cycle.
REQ-033 The buffer SHALL pop when if_valid && !id_stall && !PCsrc.
REQ-034 A simultaneous push and pop SHALL leave count unchanged.
REQ-035 Overflow is impossible because requests are gated by count<2.
REQ-036 if_valid = (count!=0); when empty, if_pc = 0 and if_inst = NOP_INST.
REQ-037 im_rvalid received in IDLE or REQ SHALL be ignored.
REQ-038 im_rvalid SHALL never be expected in the same cycle as its own im_gnt (minimum latency 1).

Reset
REQ-039 On rst: state = IDLE, count = 0, im_req = 0, IM_stall = 1, if_valid = 0, if_pc = 0, if_inst = NOP_INST.
REQ-040 rst asserted mid-transaction SHALL abandon the outstanding request; a late im_rvalid after reset SHALL be ignored per REQ-037.

Structure
REQ-041 Shared package fetch_pkg SHALL hold the enum fetch_state_t, the constant NOP_INST_C = 32'h0000_0013, and the typedef fetch_entry_t {pc[31:0], inst[31:0]}.
REQ-042 Sub-module fetch_buffer SHALL implement the 2-entry FIFO of fetch_entry_t with push, pop, flush and count.

Verification
REQ-043 Reset, then pc_in = 0x0, gnt next cycle, rvalid 2 cycles later with 0x00500093 -> IM_stall low for 1 cycle, next cycle if_valid = 1, if_pc = 0x0, if_inst = 0x00500093.
REQ-044 id_stall held high, three sequential fetches -> exactly 2 buffered entries (0x0, 0x4), no third im_req until a pop.
REQ-045 PCsrc asserted in WAIT with pc_in then 0x100 -> old response dropped, buffer empty, next granted im_addr = 0x100.
REQ-046 pc_hold high when rvalid arrives (data 0x00000013, pc 0x8) -> HOLD, IM_stall stays 1; pc_hold drops -> IM_stall low 1 cycle, entry pushed.
REQ-047 PCsrc and im_gnt in the same cycle -> DROP; the following rvalid is discarded; if_valid stays 0.
REQ-048 rst in WAIT followed by a stray rvalid -> ignored, if_valid = 0, if_inst = 0x00000013.
